// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of a combinational 8-bit ALU: registers operands,
// waits SETTLE_CYCLES, captures result/flags, maintains an accumulator.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  input  logic       cmd_wb,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_ov,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic       rsp_err,
  output logic [7:0] acc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT  = 4'(SETTLE_CYCLES - 32'd1);
  localparam logic [3:0] ILLEGAL_FLAGS = 4'b0100;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op > 4'd8);
  endfunction

  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic n, input logic ov);
    return {c, z, n, ov};
  endfunction

  state_t     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic       wb_r, wb_s;
  logic       err_r, err_s;
  logic [7:0] alu_a_s, alu_b_s;
  logic [3:0] alu_op_s;
  logic [7:0] rsp_result_s;
  logic [3:0] rsp_flags_s;
  logic       rsp_err_s;
  logic [7:0] acc_s;
  logic       cmd_ready_s, rsp_valid_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    wb_s         = wb_r;
    err_s        = err_r;
    alu_a_s      = alu_a;
    alu_b_s      = alu_b;
    alu_op_s     = alu_op;
    rsp_result_s = rsp_result;
    rsp_flags_s  = rsp_flags;
    rsp_err_s    = rsp_err;
    acc_s        = acc;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_s  = cmd_use_acc ? acc : cmd_a;
          alu_b_s  = cmd_b;
          alu_op_s = cmd_op;
          wb_s     = cmd_wb;
          err_s    = is_illegal(cmd_op);
          cnt_s    = SETTLE_INIT;
          state_s  = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          // Illegal opcodes never let ALU output reach the response or acc.
          if (err_r) begin
            rsp_result_s = 8'h00;
            rsp_flags_s  = ILLEGAL_FLAGS;
            rsp_err_s    = 1'b1;
          end else begin
            rsp_result_s = alu_result;
            rsp_flags_s  = pack_flags(alu_c, alu_z, alu_n, alu_ov);
            rsp_err_s    = 1'b0;
          end
          if (wb_r && !err_r) begin
            acc_s = alu_result;
          end else begin
            acc_s = acc;
          end
          state_s = RESP;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          state_s = EXEC;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    cmd_ready_s = (state_s == IDLE);
    rsp_valid_s = (state_s == RESP);
  end

  // Datapath and handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 4'd0;
      wb_r       <= 1'b0;
      err_r      <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_op     <= 4'd0;
      rsp_result <= 8'h00;
      rsp_flags  <= 4'b0000;
      rsp_err    <= 1'b0;
      acc        <= 8'h00;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      wb_r       <= wb_s;
      err_r      <= err_s;
      alu_a      <= alu_a_s;
      alu_b      <= alu_b_s;
      alu_op     <= alu_op_s;
      rsp_result <= rsp_result_s;
      rsp_flags  <= rsp_flags_s;
      rsp_err    <= rsp_err_s;
      acc        <= acc_s;
      cmd_ready  <= cmd_ready_s;
      rsp_valid  <= rsp_valid_s;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer with a behavioural ALU model
// closing the loop on alu_a/alu_b/alu_op.
module tb_alu_op_sequencer;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_use_acc, cmd_wb;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  logic       alu_c, alu_z, alu_n, alu_ov;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_result, acc;
  logic [3:0] rsp_flags;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wb(cmd_wb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_ov(alu_ov),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc(acc)
  );

  always #5 clk = ~clk;

  // Reference ALU: C is carry (add/inc/shl/shr) or borrow (sub/dec).
  logic [7:0] m_r;
  logic       m_c, m_ov;
  always_comb begin
    m_r = 8'h00; m_c = 1'b0; m_ov = 1'b0;
    case (alu_op)
      4'd0: begin {m_c, m_r} = {1'b0, alu_a} + {1'b0, alu_b};
                  m_ov = (alu_a[7] == alu_b[7]) && (m_r[7] != alu_a[7]); end
      4'd1: begin m_r = alu_a - alu_b; m_c = (alu_a < alu_b);
                  m_ov = (alu_a[7] != alu_b[7]) && (m_r[7] != alu_a[7]); end
      4'd2: m_r = alu_a & alu_b;
      4'd3: m_r = alu_a | alu_b;
      4'd4: m_r = alu_a;
      4'd5: begin m_r = {alu_a[6:0], 1'b0}; m_c = alu_a[7]; end
      4'd6: begin m_r = {1'b0, alu_a[7:1]}; m_c = alu_a[0]; end
      4'd7: begin m_r = alu_b + 8'd1; m_c = (alu_b == 8'hFF); m_ov = (alu_b == 8'h7F); end
      4'd8: begin m_r = alu_b - 8'd1; m_c = (alu_b == 8'h00); m_ov = (alu_b == 8'h80); end
      default: begin m_r = 8'hAA; m_c = 1'b1; m_ov = 1'b1; end
    endcase
    alu_result = m_r;
    alu_c = m_c; alu_z = (m_r == 8'h00); alu_n = m_r[7]; alu_ov = m_ov;
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic       wb;
    logic [7:0] exp_result;
    logic [3:0] exp_flags;
    logic       exp_err;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] model_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full command: drive at a negedge, track latency, check response and handshake.
  task automatic run_vec(input vec_t v);
    int k;
    logic [7:0] exp_a;
    exp_a = v.use_acc ? model_acc : v.a;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
    cmd_use_acc = v.use_acc; cmd_wb = v.wb;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    chk("alu_a", {24'd0, alu_a}, {24'd0, exp_a});
    chk("alu_b", {24'd0, alu_b}, {24'd0, v.b});
    chk("alu_op", {28'd0, alu_op}, {28'd0, v.op});
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, S + 1);
    chk("rsp_result", {24'd0, rsp_result}, {24'd0, v.exp_result});
    chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, v.exp_flags});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("acc", {24'd0, acc}, {24'd0, v.exp_acc});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("alu_a_hold", {24'd0, alu_a}, {24'd0, exp_a});
    model_acc = v.exp_acc;
  endtask

  initial begin
    //        op     a      b      ua    wb    result flags    err   acc
    vecs[0]  = '{4'd0, 8'h3C, 8'h05, 1'b0, 1'b1, 8'h41, 4'b0000, 1'b0, 8'h41};
    vecs[1]  = '{4'd1, 8'h00, 8'h41, 1'b1, 1'b1, 8'h00, 4'b0100, 1'b0, 8'h00};
    vecs[2]  = '{4'd8, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 4'b1010, 1'b0, 8'h00};
    vecs[3]  = '{4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0011, 1'b0, 8'h00};
    vecs[4]  = '{4'd5, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 4'b1000, 1'b0, 8'h00};
    vecs[5]  = '{4'd6, 8'h81, 8'h00, 1'b0, 1'b0, 8'h40, 4'b1000, 1'b0, 8'h00};
    vecs[6]  = '{4'd4, 8'h55, 8'h00, 1'b0, 1'b1, 8'h55, 4'b0000, 1'b0, 8'h55};
    vecs[7]  = '{4'd12, 8'h33, 8'h11, 1'b0, 1'b1, 8'h00, 4'b0100, 1'b1, 8'h55};
    vecs[8]  = '{4'd2, 8'h00, 8'h0F, 1'b1, 1'b1, 8'h05, 4'b0000, 1'b0, 8'h05};
    vecs[9]  = '{4'd3, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 4'b0010, 1'b0, 8'h05};
    vecs[10] = '{4'd7, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 4'b1100, 1'b0, 8'h00};
    vecs[11] = '{4'd9, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 8'h00};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_use_acc = 1'b0; cmd_wb = 1'b0; rsp_ready = 1'b0; model_acc = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_acc", {24'd0, acc}, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: first command completes, second is held on the bus throughout.
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h10; cmd_b = 8'h20; cmd_use_acc = 1'b0; cmd_wb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 4'd2; cmd_a = 8'hF0; cmd_b = 8'h0F; cmd_wb = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_result_stable", {24'd0, rsp_result}, 32'h30);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_alu_op_held", {28'd0, alu_op}, 32'd0);
      chk("bp_acc", {24'd0, acc}, 32'h30);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release_idle", {31'd0, cmd_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_accept", {28'd0, alu_op}, 32'd2);
    chk("bp_second_a", {24'd0, alu_a}, 32'hF0);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    chk("bp2_result", {24'd0, rsp_result}, 32'h00);
    chk("bp2_flags", {28'd0, rsp_flags}, 32'h4);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of EXEC with write-back requested.
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h11; cmd_b = 8'h22; cmd_wb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_result", {24'd0, rsp_result}, 32'd0);
    chk("mid_rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    chk("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("mid_rst_acc", {24'd0, acc}, 32'd0);
    chk("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("mid_rst_alu_b", {24'd0, alu_b}, 32'd0);
    chk("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
    for (int k = 0; k < S + 3; k++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_acc_hold", {24'd0, acc}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
